hdmi_tx_scheduler: RTL

//  Sequences the three TMDS encoders (B=ch0, G=ch1, R=ch2) of the HDMI transmitter.
//  - Generates raster timing (h/v counters, HS/VS).
//  - Schedules each line's control period, video preamble (8 clk), video guard band (2 clk) and active video.
//  - Pulls pixels from upstream.
//  - Drives encoder DE/ctrl/data, plus a latency-matched guard-band override for the post-encoder mux.

---
 rtl/hdmi_tmds_pkg.sv | 30 +++
 rtl/hdmi_timing_counter.sv | 69 ++++++
 rtl/hdmi_tx_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_tmds_pkg.sv
// Shared types and constants for the HDMI TMDS transmit scheduler.
// Holds the scheduler state enum, the pixel payload struct, the fixed
// video guard-band words and the video preamble control token.
package hdmi_tmds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CTRL   = 3'd1,
        ST_PRE    = 3'd2,
        ST_GUARD  = 3'd3,
        ST_ACTIVE = 3'd4
    } sched_state_t;

    // Upstream pixel word {R,G,B}
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [9:0] GB_CH02 = 10'b1011001100;
    localparam logic [9:0] GB_CH1  = 10'b0100110011;

    // {CTL3,CTL2,CTL1,CTL0} during the video preamble
    localparam logic [3:0] CTL_VIDEO = 4'b0001;

    localparam int unsigned PRE_LEN = 8;
    localparam int unsigned GB_LEN  = 2;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters for the HDMI transmitter.
// Ports:
//   pclk, rst_n          clock, async active-low reset
//   run                  counters advance while high, held at 0 while low
//   start                load the line position that precedes line 0
//   h_cnt, v_cnt         current raster position
//   hs_c, vs_c           sync regions (active-high, polarity applied by the user)
//   frame_end_c          last clock of the frame
//   next_line_active_c   the line after the current one carries video
module hdmi_timing_counter #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned H_START  = 0,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          start,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hs_c,
    output logic          vs_c,
    output logic          frame_end_c,
    output logic          next_line_active_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_LOAD = HW'(H_START);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic line_end_c;

    assign line_end_c  = (h_cnt == H_LAST);
    assign frame_end_c = line_end_c && (v_cnt == V_LAST);
    assign hs_c = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_c = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    // Next line wraps to line 0 after the last line, which is always active
    assign next_line_active_c = (v_cnt == V_LAST) || (32'(v_cnt) + 32'd1 < V_ACTIVE);

    // Start places the raster on the last line, just ahead of the line-0 preamble
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (start) begin
            h_cnt <= H_LOAD;
            v_cnt <= V_LAST;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end_c) begin
            h_cnt <= '0;
            v_cnt <= frame_end_c ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/hdmi_tx_scheduler.sv
// HDMI transmit scheduler: raster timing, per-line control/preamble/guard/
// active sequencing, pixel fetch and TMDS encoder input drive.
// Build option: define HDMI_GUARD_BAND_EN for HDMI mode (preamble + video
// guard band); leave undefined for DVI mode (no preamble, CTL0..3 = 0,
// gb_sel = 0, identical raster and pixel timing).
// Ports:
//   pclk, rst_n, en              clock, async reset, run enable (frame boundary)
//   pix_valid, pix_rgb, pix_req  show-ahead pixel interface {R,G,B}
//   frame_start                  first active pixel of a frame at encoder input
//   enc_de, enc_b/g/r            encoder DE and data
//   enc_ctrl0/1/2                {VS,HS}, {CTL1,CTL0}, {CTL3,CTL2}
//   gb_sel, gb_word0/1/2         guard-band override aligned to encoder output
//   underflow                    sticky: pixel requested while none valid
module hdmi_tx_scheduler
    import hdmi_tmds_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned ENC_LAT  = 3
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_req,
    output logic        frame_start,
    output logic        enc_de,
    output logic [7:0]  enc_b,
    output logic [7:0]  enc_g,
    output logic [7:0]  enc_r,
    output logic [1:0]  enc_ctrl0,
    output logic [1:0]  enc_ctrl1,
    output logic [1:0]  enc_ctrl2,
    output logic        gb_sel,
    output logic [9:0]  gb_word0,
    output logic [9:0]  gb_word1,
    output logic [9:0]  gb_word2,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned H_START = H_TOTAL - PRE_LEN - GB_LEN;
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [1:0]    SYNC_IDLE  = {~VS_POL, ~HS_POL};
`ifdef HDMI_GUARD_BAND_EN
    localparam int unsigned   GBW         = ENC_LAT + 1;
    localparam logic [HW-1:0] H_PRE_DECIDE = HW'(H_START - 1);
    localparam logic [HW-1:0] H_PRE_LAST   = HW'(H_TOTAL - GB_LEN - 1);
    logic                     guard_d;
    logic [GBW-1:0]           gb_pipe;
`endif

    sched_state_t  state, state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_c, vs_c, frame_end_c, next_line_active_c;
    logic          cnt_start_c, cnt_run_c;
    logic          de_d, fs_d;
    logic [1:0]    ctrl0_d;
    logic [3:0]    ctl_d;
    rgb_t          px;
    logic          take_c;

    assign cnt_start_c = (state == ST_IDLE) && en;
    assign cnt_run_c   = (state_nxt != ST_IDLE);
    assign px          = pix_rgb;
    assign take_c      = pix_req && pix_valid;

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_START  (H_START),  .HW   (HW),   .VW     (VW)
    ) u_timing (
        .pclk               (pclk),
        .rst_n              (rst_n),
        .run                (cnt_run_c),
        .start              (cnt_start_c),
        .h_cnt              (h_cnt),
        .v_cnt              (v_cnt),
        .hs_c               (hs_c),
        .vs_c               (vs_c),
        .frame_end_c        (frame_end_c),
        .next_line_active_c (next_line_active_c)
    );

    // State register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and next encoder-side values
    always_comb begin
        state_nxt = state;
        de_d      = 1'b0;
        fs_d      = 1'b0;
        ctrl0_d   = SYNC_IDLE;
        ctl_d     = '0;
`ifdef HDMI_GUARD_BAND_EN
        guard_d   = 1'b0;
`endif
        if (state != ST_IDLE)
            ctrl0_d = {vs_c ? VS_POL : ~VS_POL, hs_c ? HS_POL : ~HS_POL};
        case (state)
            // The enabling IDLE cycle stands in for the h=H_TOTAL-11 control cycle
`ifdef HDMI_GUARD_BAND_EN
            ST_IDLE:   if (en) state_nxt = ST_PRE;
            ST_CTRL:   if (h_cnt == H_PRE_DECIDE && next_line_active_c) state_nxt = ST_PRE;
            ST_PRE: begin
                ctl_d = CTL_VIDEO;
                if (h_cnt == H_PRE_LAST) state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                ctl_d   = CTL_VIDEO;
                guard_d = 1'b1;
                if (h_cnt == H_LAST) state_nxt = ST_ACTIVE;
            end
`else
            ST_IDLE:   if (en) state_nxt = ST_CTRL;
            ST_CTRL:   if (h_cnt == H_LAST && next_line_active_c) state_nxt = ST_ACTIVE;
`endif
            ST_ACTIVE: begin
                de_d = 1'b1;
                fs_d = (h_cnt == '0) && (v_cnt == '0);
                if (h_cnt == H_ACT_LAST) state_nxt = ST_CTRL;
            end
            default:   state_nxt = ST_IDLE;
        endcase
        // en is honoured only on the last clock of a frame
        if (state != ST_IDLE && frame_end_c && !en)
            state_nxt = ST_IDLE;
    end

    // Encoder-side output registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            enc_de      <= 1'b0;
            enc_b       <= '0;
            enc_g       <= '0;
            enc_r       <= '0;
            enc_ctrl0   <= SYNC_IDLE;
            enc_ctrl1   <= '0;
            enc_ctrl2   <= '0;
            gb_word0    <= '0;
            gb_word1    <= '0;
            gb_word2    <= '0;
            underflow   <= 1'b0;
        end else begin
            pix_req     <= (state_nxt == ST_ACTIVE);
            frame_start <= fs_d;
            enc_de      <= de_d;
            enc_b       <= take_c ? px.b : '0;
            enc_g       <= take_c ? px.g : '0;
            enc_r       <= take_c ? px.r : '0;
            enc_ctrl0   <= ctrl0_d;
            enc_ctrl1   <= ctl_d[1:0];
            enc_ctrl2   <= ctl_d[3:2];
            gb_word0    <= GB_CH02;
            gb_word1    <= GB_CH1;
            gb_word2    <= GB_CH02;
            underflow   <= underflow | (pix_req & ~pix_valid);
        end
    end

`ifdef HDMI_GUARD_BAND_EN
    // Guard flag delayed to match the encoder pipeline
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) gb_pipe <= '0;
        else        gb_pipe <= (gb_pipe << 1) | GBW'(guard_d);
    end
    assign gb_sel = gb_pipe[GBW-1];
`else
    assign gb_sel = 1'b0;
`endif

endmodule
